// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART state encoding and line levels (TX and RX).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int   DEFAULT_CLK_DIV = 868;
  localparam logic IDLE_LEVEL      = 1'b1;
  localparam logic START_LEVEL     = 1'b0;

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Bit-period counter 0..CLK_DIV-1 with clear and wrap tick.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [CW-1:0] r_count;

  // Explicit terminal compare so non-power-of-two dividers wrap correctly.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (r_count == C_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + C_ONE;
    end
  end

  assign o_tick = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter, LSB first, ready/start handshake.
//               Define UART_TX_PARITY_EN to add an even-parity bit (8E1).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 tx_start,
  output logic                 ready,
  output logic                 done,
  output logic                 Tx
);

  localparam int            IW         = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] C_LAST_BIT = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] C_ONE      = IW'(1);

  uart_state_t          r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [IW-1:0]        r_index;
  logic                 w_tick;
  logic                 w_baud_clear;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  // Counter is held at zero while idle so START always begins a full period.
  assign w_baud_clear = (r_state == IDLE);

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_baud_clear),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      Tx       <= IDLE_LEVEL;
      ready    <= 1'b1;
      done     <= 1'b0;
      r_shift  <= '0;
      r_index  <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (tx_start && ready) begin
            r_shift  <= din;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^din;
`endif
            r_state  <= START;
            Tx       <= START_LEVEL;
            ready    <= 1'b0;
          end
        end
        START: begin
          if (w_tick) begin
            r_state <= DATA;
            r_index <= '0;
            Tx      <= r_shift[0];
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            if (r_index == C_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
              Tx      <= r_parity;
`else
              r_state <= STOP;
              Tx      <= IDLE_LEVEL;
`endif
            end else begin
              r_index <= r_index + C_ONE;
              Tx      <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_state <= STOP;
            Tx      <= IDLE_LEVEL;
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
            Tx      <= IDLE_LEVEL;
            ready   <= 1'b1;
            done    <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          Tx      <= IDLE_LEVEL;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Scoreboard bench for uart_tx with a cycle-level line model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int D  = 4;
  localparam int N  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = N + 3;
`else
  localparam int NB = N + 2;
`endif
  localparam int SB = 1024;

  logic         clk      = 1'b0;
  logic         reset    = 1'b1;
  logic         tx_start = 1'b0;
  logic [N-1:0] din      = '0;
  logic         ready;
  logic         done;
  logic         Tx;

  uart_tx #(
    .CLK_DIV   (D),
    .DATA_BITS (N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .tx_start (tx_start),
    .ready    (ready),
    .done     (done),
    .Tx       (Tx)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a bit vector, each bit lasts D clocks.
  int            cyc     = 0;
  bit            m_busy  = 1'b0;
  bit            m_done  = 1'b0;
  int            m_start = 0;
  logic [NB-1:0] m_frame = '1;
  logic [N-1:0]  sb_data [SB];
  int            sb_cyc  [SB];
  int            sb_wr    = 0;
  int            sb_flush = 0;

  function automatic logic [NB-1:0] make_frame(input logic [N-1:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc    = cyc + 1;
      m_done = 1'b0;
      if (reset) begin
        m_busy   = 1'b0;
        sb_flush = sb_wr;
      end else if (m_busy) begin
        if (cyc - m_start == NB * D) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (tx_start) begin
        m_busy        = 1'b1;
        m_start       = cyc;
        m_frame       = make_frame(din);
        sb_data[sb_wr] = din;
        sb_cyc[sb_wr]  = cyc + NB * D;
        sb_wr         = sb_wr + 1;
      end
    end
  end

  // Monitor / scoreboard
  int   checks  = 0;
  int   errors  = 0;
  int   sb_rd   = 0;
  bit   end_req = 1'b0;
  logic txlog [int];

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  initial begin
    int           start;
    logic [N-1:0] dec;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        txlog[cyc] = Tx;
        check("ready", int'(ready), int'(!m_busy));
        check("done", int'(done), int'(m_done));
        check("tx", int'(Tx), m_busy ? int'(m_frame[(cyc - m_start) / D]) : 1);
        if (sb_rd < sb_flush) sb_rd = sb_flush;
        if (done === 1'b1) begin
          if (sb_rd == sb_wr) begin
            check("done_unexpected", 1, 0);
          end else begin
            start = sb_cyc[sb_rd] - NB * D;
            for (int i = 0; i < N; i++) dec[i] = txlog[start + (i + 1) * D + D / 2];
            check("done_cycle", cyc, sb_cyc[sb_rd]);
            check("rx_byte", int'(dec), int'(sb_data[sb_rd]));
`ifdef UART_TX_PARITY_EN
            check("rx_parity", int'(txlog[start + (N + 1) * D + D / 2]), int'(^sb_data[sb_rd]));
`endif
            sb_rd = sb_rd + 1;
          end
        end
        if (end_req) begin
          check("sb_empty", sb_wr - sb_rd, 0);
          $display("Simulation finished: %0d checks, %0d errors", checks, errors);
          $finish;
        end
      end
    end
  end

  // Stimulus
  task automatic wait_idle();
    int n = 0;
    while (m_busy) begin
      @(negedge clk);
      n = n + 1;
      if (n > 2000) begin
        $display("FAIL wait_idle: got busy after %0d cycles, expected idle", n);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic send(input logic [N-1:0] b);
    wait_idle();
    tx_start = 1'b1;
    din      = b;
    @(negedge clk);
    tx_start = 1'b0;
    din      = N'($urandom);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);

    send(8'hA5);
    wait_idle();
    repeat (3) @(negedge clk);

    // Back-to-back: start held through the first done cycle.
    tx_start = 1'b1;
    din      = 8'h00;
    @(negedge clk);
    din = 8'hFF;
    wait_idle();
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Start request during DATA must be ignored.
    send(8'h96);
    repeat (2 * D) @(negedge clk);
    tx_start = 1'b1;
    din      = 8'h3C;
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle();
    repeat (4 * D) @(negedge clk);

    // Reset in the middle of DATA.
    send(8'h81);
    repeat (3 * D) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send(8'h42);
    wait_idle();
    repeat (3) @(negedge clk);

    send(8'h07);
    send(8'h03);
    wait_idle();
    repeat (3) @(negedge clk);

    for (int i = 0; i < 1500; i++) begin
      tx_start = ($urandom_range(0, 3) == 0);
      din      = N'($urandom);
      reset    = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    tx_start = 1'b0;
    reset    = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    end_req = 1'b1;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter feeding the Bluetooth module's RX pin; the counterpart of the receiver on the Rx line.
- Frame: 8N1 by default, LSB first, idle-high line, one bit period = CLK_DIV clocks (868 at 100 MHz gives about 115200 baud).
- Sits between game/control logic, which offers bytes through a ready/start handshake, and the Tx pad.

Parameters:
- CLK_DIV, 868, clocks per bit period; legal range >= 2.
- DATA_BITS, 8, data bits per frame; din width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- din  in  DATA_BITS  byte to send; sampled only in the accept cycle.
- tx_start  in  1  request to send din.
- ready  out  1  high when idle and able to accept.
- done  out  1  one-clock pulse when the stop bit completes.
- Tx  out  1  serial line, registered output, idle high.

Behaviour:
- Reset (sync, active-high): state IDLE, Tx=1, ready=1, done=0, baud counter=0, bit index=0, shift register=0.
- Accept: tx_start=1 and ready=1 at a rising edge.
  - din latches into the shift register.
  - Next cycle: state START, Tx=0, ready=0, counter=0.
- tx_start while ready=0 is ignored; no queuing. din changes after accept have no effect.
- Baud counter runs 0..CLK_DIV-1 in every non-IDLE state. Wrap (count==CLK_DIV-1) ends the current bit. Each bit is exactly CLK_DIV clocks on Tx.
- FSM states:
  - IDLE: Tx=1, ready=1. Accept -> START.
  - START: Tx=0. On wrap -> DATA, bit index=0.
  - DATA: Tx = shift[0]. On wrap, shift right. Index increments; at index DATA_BITS-1 the next state is STOP (or PARITY when the optional feature is enabled).
  - STOP: Tx=1. On wrap -> IDLE. done=1 and ready=1 in the first IDLE cycle; done is low otherwise.
- Latency: Tx falls 1 clock after the accept edge. done asserts (DATA_BITS+2)*CLK_DIV + 1 clocks after the accept edge.
- Back-to-back: tx_start held high in the done cycle is accepted. The line is high for exactly 1 extra clock between frames; no other idle gap is inserted.
- Reset mid-frame: next edge forces IDLE with Tx=1. No done pulse; the partial frame is abandoned.
- Width rules:
  - Counter width = clog2(CLK_DIV).
  - Bit index width = clog2(DATA_BITS+1).
  - No arithmetic overflow is permitted: explicit compare-to-terminal, never rely on natural wrap.
- Outputs are glitch-free: Tx, ready and done are all flops.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - Tx = even parity (XOR of the latched byte) for CLK_DIV clocks.
  - Frame is 11 bits; done latency becomes (DATA_BITS+3)*CLK_DIV + 1.
  - Parity is computed from the latched byte at accept, not from the shifting register.
- Undefined: no PARITY state; 8N1 frame exactly as above.

Decomposition:
- Package uart_pkg:
  - state encoding (IDLE, START, DATA, PARITY, STOP) as a 3-bit typedef;
  - DEFAULT_CLK_DIV=868;
  - IDLE_LEVEL=1'b1, START_LEVEL=1'b0.
  - Shared with the receiver rewrite.
- One sub-module, uart_baud_gen:
  - counter with clear input and a wrap/tick output, parameter CLK_DIV;
  - reused by the receiver at CLK_DIV/2 offset sampling.

Test Plan:
- Reset, then hold reset=0 for 50 clocks with tx_start=0 -> Tx=1, ready=1, done=0 throughout.
- CLK_DIV=4, din=8'hA5, single tx_start pulse -> Tx sequence per 4-clock period: 0,1,0,1,0,0,1,0,1,1. done pulses once at clock 41 after accept. ready returns high in the same cycle.
- CLK_DIV=4, tx_start held high, din=8'h00 then 8'hFF -> two frames. Exactly one idle-high clock between the first stop bit and the second start bit. Both done pulses are present.
- CLK_DIV=4, tx_start pulsed during DATA with din=8'h3C -> ignored. The frame in flight is unchanged, and no second frame follows.
- CLK_DIV=4, reset asserted mid-DATA of 8'h81 -> Tx=1 on the next clock, ready=1, no done pulse. A new byte 8'h42 then transmits correctly.
- UART_TX_PARITY_EN, CLK_DIV=4, din=8'h07 -> parity bit 1 after data, 11-bit frame, done at clock 45. With din=8'h03 the parity bit is 0.
